ysyx_23060203_axi_rd_arb: RTL

Two-master, one-slave AXI read-channel arbiter that shares a single read-only device port (CLINT, boot ROM, etc.) between the IFU and the LSU. It grants whole transactions round-robin, forwards the AR beat of the winner, and steers every R beat back to the owner until `rlast`. It sits between the core's two fetch/load masters and the device crossbar leg.

---
 rtl/ysyx_23060203_axi_rd_arb.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/ysyx_23060203_axi_rd_arb.sv
// Two-master, one-slave AXI read-channel arbiter.
// Shares one read-only device port between the IFU (master 0) and the LSU (master 1).
// Whole transactions are granted round-robin. The winner's AR beat is forwarded, and
// every R beat is steered back to the owner until the rlast handshake.
//
// Ports:
//   clock, reset          : single clock, asynchronous active-low reset
//   i_ifu_* / o_ifu_*     : IFU read master (AR request in, AR ready and R beat out)
//   i_lsu_* / o_lsu_*     : LSU read master (same subset)
//   o_out_* / i_out_*     : shared slave side (AR request out, R beat in)
//   write-channel handshakes are tied off on both sides
module ysyx_23060203_axi_rd_arb #(
  parameter bit          LSU_FIRST = 1'b1,
  parameter int unsigned AddrWidth = 32,
  parameter int unsigned DataWidth = 32,
  parameter int unsigned IdWidth   = 4
) (
  input  logic                 clock,
  input  logic                 reset,
  // IFU master
  input  logic [AddrWidth-1:0] i_ifu_araddr,
  input  logic                 i_ifu_arvalid,
  output logic                 o_ifu_arready,
  input  logic [IdWidth-1:0]   i_ifu_arid,
  input  logic [7:0]           i_ifu_arlen,
  input  logic [2:0]           i_ifu_arsize,
  input  logic [1:0]           i_ifu_arburst,
  output logic                 o_ifu_rvalid,
  input  logic                 i_ifu_rready,
  output logic [DataWidth-1:0] o_ifu_rdata,
  output logic [1:0]           o_ifu_rresp,
  output logic                 o_ifu_rlast,
  output logic [IdWidth-1:0]   o_ifu_rid,
  output logic                 o_ifu_awready,
  output logic                 o_ifu_wready,
  output logic                 o_ifu_bvalid,
  // LSU master
  input  logic [AddrWidth-1:0] i_lsu_araddr,
  input  logic                 i_lsu_arvalid,
  output logic                 o_lsu_arready,
  input  logic [IdWidth-1:0]   i_lsu_arid,
  input  logic [7:0]           i_lsu_arlen,
  input  logic [2:0]           i_lsu_arsize,
  input  logic [1:0]           i_lsu_arburst,
  output logic                 o_lsu_rvalid,
  input  logic                 i_lsu_rready,
  output logic [DataWidth-1:0] o_lsu_rdata,
  output logic [1:0]           o_lsu_rresp,
  output logic                 o_lsu_rlast,
  output logic [IdWidth-1:0]   o_lsu_rid,
  output logic                 o_lsu_awready,
  output logic                 o_lsu_wready,
  output logic                 o_lsu_bvalid,
  // Shared slave
  output logic [AddrWidth-1:0] o_out_araddr,
  output logic                 o_out_arvalid,
  input  logic                 i_out_arready,
  output logic [IdWidth-1:0]   o_out_arid,
  output logic [7:0]           o_out_arlen,
  output logic [2:0]           o_out_arsize,
  output logic [1:0]           o_out_arburst,
  input  logic                 i_out_rvalid,
  output logic                 o_out_rready,
  input  logic [DataWidth-1:0] i_out_rdata,
  input  logic [1:0]           i_out_rresp,
  input  logic                 i_out_rlast,
  input  logic [IdWidth-1:0]   i_out_rid,
  output logic                 o_out_awvalid,
  output logic                 o_out_wvalid,
  output logic                 o_out_bready
);

  typedef enum logic [1:0] {StIdle, StAddr, StData} st_e;

  st_e  r_st;
  logic r_gnt;  // 0 = IFU, 1 = LSU
  logic r_pri;  // requester that wins a tie in IDLE

  logic w_ar_hs;
  logic w_r_last_hs;

  assign w_ar_hs     = o_out_arvalid & i_out_arready;
  assign w_r_last_hs = i_out_rvalid & o_out_rready & i_out_rlast;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_st  <= StIdle;
      r_gnt <= 1'b0;
      r_pri <= LSU_FIRST;
    end else begin
      unique case (r_st)
        StIdle: begin
          if (i_ifu_arvalid | i_lsu_arvalid) begin
            // A lone requester wins outright; a tie goes to the priority holder.
            r_gnt <= (i_ifu_arvalid & i_lsu_arvalid) ? r_pri : i_lsu_arvalid;
            r_st  <= StAddr;
          end
        end
        StAddr: begin
          if (w_ar_hs) r_st <= StData;
        end
        StData: begin
          if (w_r_last_hs) begin
            r_st  <= StIdle;
            r_pri <= ~r_gnt;
          end
        end
        default: r_st <= StIdle;
      endcase
    end
  end

  // AR and R paths are pure combinational passthrough so no beat picks up latency.
  always_comb begin
    o_ifu_arready = 1'b0;
    o_lsu_arready = 1'b0;
    o_out_araddr  = '0;
    o_out_arvalid = 1'b0;
    o_out_arid    = '0;
    o_out_arlen   = '0;
    o_out_arsize  = '0;
    o_out_arburst = '0;
    o_out_rready  = 1'b0;
    o_ifu_rvalid  = 1'b0;
    o_ifu_rdata   = '0;
    o_ifu_rresp   = '0;
    o_ifu_rlast   = 1'b0;
    o_ifu_rid     = '0;
    o_lsu_rvalid  = 1'b0;
    o_lsu_rdata   = '0;
    o_lsu_rresp   = '0;
    o_lsu_rlast   = 1'b0;
    o_lsu_rid     = '0;
    if (r_st == StAddr) begin
      if (r_gnt) begin
        o_out_araddr  = i_lsu_araddr;
        o_out_arvalid = i_lsu_arvalid;
        o_out_arid    = i_lsu_arid;
        o_out_arlen   = i_lsu_arlen;
        o_out_arsize  = i_lsu_arsize;
        o_out_arburst = i_lsu_arburst;
        o_lsu_arready = i_out_arready;
      end else begin
        o_out_araddr  = i_ifu_araddr;
        o_out_arvalid = i_ifu_arvalid;
        o_out_arid    = i_ifu_arid;
        o_out_arlen   = i_ifu_arlen;
        o_out_arsize  = i_ifu_arsize;
        o_out_arburst = i_ifu_arburst;
        o_ifu_arready = i_out_arready;
      end
    end
    if (r_st == StData) begin
      if (r_gnt) begin
        o_lsu_rvalid = i_out_rvalid;
        o_lsu_rdata  = i_out_rdata;
        o_lsu_rresp  = i_out_rresp;
        o_lsu_rlast  = i_out_rlast;
        o_lsu_rid    = i_out_rid;
        o_out_rready = i_lsu_rready;
      end else begin
        o_ifu_rvalid = i_out_rvalid;
        o_ifu_rdata  = i_out_rdata;
        o_ifu_rresp  = i_out_rresp;
        o_ifu_rlast  = i_out_rlast;
        o_ifu_rid    = i_out_rid;
        o_out_rready = i_ifu_rready;
      end
    end
  end

  assign o_ifu_awready = 1'b0;
  assign o_ifu_wready  = 1'b0;
  assign o_ifu_bvalid  = 1'b0;
  assign o_lsu_awready = 1'b0;
  assign o_lsu_wready  = 1'b0;
  assign o_lsu_bvalid  = 1'b0;
  assign o_out_awvalid = 1'b0;
  assign o_out_wvalid  = 1'b0;
  assign o_out_bready  = 1'b0;

endmodule
